hash_controller: RTL and testbench

Top-level sequencer for the hash generator. It accepts one block-hash request from the host and pulses the message/initial-state loads. It then runs `NUM_ROUNDS` rounds by handshaking with the round controller (`start_rnd` / `done_rnd`), commits each round result, and reports completion. It sits between the host interface and the round controller / hash datapath.

---
 rtl/hash_controller.sv | 142 ++++++++++++++
 tb/tb_hash_controller.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_controller.sv
// Top-level block-hash sequencer: loads message/IV, handshakes NUM_ROUNDS rounds with the round
// controller, commits each result and pulses done. Define HASH_CTRL_TIMEOUT_EN for the watchdog.
module hash_controller #(
  parameter int unsigned NUM_ROUNDS  = 8,
  parameter int unsigned TIMEOUT_CYC = 255,
  localparam int unsigned RoundW     = (NUM_ROUNDS > 2) ? $clog2(NUM_ROUNDS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              done_rnd_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              ld_msg_o,
  output logic              ld_hash_init_o,
  output logic              start_rnd_o,
  output logic              upd_hash_o,
  output logic [RoundW-1:0] round_idx_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [RoundW-1:0] LastRound = RoundW'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StKick,
    StArm,
    StRun,
    StUpdate,
    StFinish
  } state_e;

  state_e            state_q, state_d;
  logic [RoundW-1:0] round_idx_q, round_idx_d;
  logic              accept;
  logic              timeout;

  assign accept = (state_q == StIdle) && start_i && done_rnd_i && !abort_i;

`ifdef HASH_CTRL_TIMEOUT_EN
  localparam int unsigned   CntW    = $clog2(TIMEOUT_CYC + 1);
  // Leave on the cycle whose increment would make the count reach TIMEOUT_CYC.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  assign timeout = ((state_q == StArm) || (state_q == StRun)) && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StKick) begin
      cnt_d = '0;
    end else if ((state_q == StArm) || (state_q == StRun)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if (timeout && !abort_i) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = |TIMEOUT_CYC;
  assign timeout            = 1'b0;
  assign err_o              = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    round_idx_d = round_idx_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d     = StLoad;
          round_idx_d = '0;
        end
      end
      StLoad:   state_d = StKick;
      StKick:   state_d = StArm;
      StArm:    if (!done_rnd_i) state_d = StRun;
      StRun:    if (done_rnd_i) state_d = StUpdate;
      StUpdate: begin
        if (round_idx_q == LastRound) begin
          state_d = StFinish;
        end else begin
          round_idx_d = round_idx_q + RoundW'(1);
          state_d     = StKick;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (abort_i && (state_q != StIdle)) begin
      state_d     = StIdle;
      round_idx_d = '0;
    end else if (timeout) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      round_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      round_idx_q <= round_idx_d;
    end
  end

  assign ready_o        = (state_q == StIdle) && done_rnd_i;
  assign busy_o         = (state_q != StIdle);
  assign ld_msg_o       = (state_q == StLoad);
  assign ld_hash_init_o = (state_q == StLoad);
  assign start_rnd_o    = (state_q == StKick);
  assign upd_hash_o     = (state_q == StUpdate);
  assign done_o         = (state_q == StFinish);
  assign round_idx_o    = round_idx_q;

endmodule

// File: tb/tb_hash_controller.sv
// Scoreboard bench for hash_controller with a behavioural round-controller model (L run cycles).
module tb_hash_controller;

  localparam int unsigned NR = 8;
  localparam int          L  = 4;
`ifdef HASH_CTRL_TIMEOUT_EN
  localparam int unsigned TO = 10;
`else
  localparam int unsigned TO = 255;
`endif

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       done_rnd;
  logic       hold_busy = 1'b0;
  logic       stuck = 1'b0;
  logic       mdl_clr = 1'b0;
  logic       ready, busy, ld_msg, ld_hash_init, start_rnd, upd_hash, done, err;
  logic [2:0] round_idx;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int kicks = 0;
  int dones = 0;
  int mcnt = 0;
  int mon_e;
  logic [2:0] mon_idx;

  int         exp_ld_q[$];
  int         exp_done_q[$];
  int         exp_upd_cyc_q[$];
  logic [2:0] exp_upd_idx_q[$];

  hash_controller #(
    .NUM_ROUNDS (NR),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .start_i       (start),
    .abort_i       (abort),
    .done_rnd_i    (done_rnd),
    .ready_o       (ready),
    .busy_o        (busy),
    .ld_msg_o      (ld_msg),
    .ld_hash_init_o(ld_hash_init),
    .start_rnd_o   (start_rnd),
    .upd_hash_o    (upd_hash),
    .round_idx_o   (round_idx),
    .done_o        (done),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Round controller: 1 INIT cycle plus L RUN cycles with done_rnd low after each start_rnd.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)        mcnt <= 0;
    else if (mdl_clr)   mcnt <= 0;
    else if (start_rnd) mcnt <= stuck ? 1000000 : L + 1;
    else if (mcnt > 0)  mcnt <= mcnt - 1;
  end
  assign done_rnd = (mcnt == 0) && !hold_busy;

  always begin
    @(negedge clk);
    if (start_rnd) kicks++;
    if (ld_msg) begin
      vecs++;
      if (exp_ld_q.size() == 0) begin
        errs++;
        $display("FAIL ld_msg: unexpected pulse at cycle %0d", cyc);
      end else begin
        mon_e = exp_ld_q.pop_front();
        if (cyc !== mon_e || ld_hash_init !== 1'b1) begin
          errs++;
          $display("FAIL ld_msg: cycle %0d ld_hash_init %b, required cycle %0d ld_hash_init 1",
                   cyc, ld_hash_init, mon_e);
        end
      end
    end
    if (upd_hash) begin
      vecs++;
      if (exp_upd_cyc_q.size() == 0) begin
        errs++;
        $display("FAIL upd_hash: unexpected pulse at cycle %0d idx %0d", cyc, round_idx);
      end else begin
        mon_e   = exp_upd_cyc_q.pop_front();
        mon_idx = exp_upd_idx_q.pop_front();
        if (cyc !== mon_e || round_idx !== mon_idx) begin
          errs++;
          $display("FAIL upd_hash: cycle %0d idx %0d, required cycle %0d idx %0d",
                   cyc, round_idx, mon_e, mon_idx);
        end
      end
    end
    if (done) begin
      vecs++;
      dones++;
      if (exp_done_q.size() == 0) begin
        errs++;
        $display("FAIL done: unexpected pulse at cycle %0d", cyc);
      end else begin
        mon_e = exp_done_q.pop_front();
        if (cyc !== mon_e) begin
          errs++;
          $display("FAIL done: cycle %0d, required %0d", cyc, mon_e);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // c is the LOAD cycle of the block.
  task automatic push_block(input int c, input int nupd, input bit with_done);
    exp_ld_q.push_back(c);
    for (int r = 0; r < nupd; r++) begin
      exp_upd_idx_q.push_back(r[2:0]);
      exp_upd_cyc_q.push_back(c + 8 + (L + 4) * r);
    end
    if (with_done) exp_done_q.push_back(c + 1 + int'(NR) * (L + 4));
  endtask

  task automatic wait_done(input int d0, input string name);
    int n = 0;
    while (dones == d0 && n < 200) begin
      step();
      n++;
    end
    vecs++;
    if (dones == d0) begin
      errs++;
      $display("FAIL %s: done not seen within 200 cycles", name);
    end
  endtask

  task automatic check_drained(input string name);
    vecs++;
    if (exp_ld_q.size() + exp_upd_cyc_q.size() + exp_done_q.size() !== 0) begin
      errs++;
      $display("FAIL %s: pending ld/upd/done %0d/%0d/%0d, required 0/0/0", name,
               exp_ld_q.size(), exp_upd_cyc_q.size(), exp_done_q.size());
    end
  endtask

  task automatic test_reset();
    #3;
    vecs++;
    if ({busy, ld_msg, ld_hash_init, start_rnd, upd_hash, done, err, round_idx} !== 10'd0
        || ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_values: outs %b ready %b, required all 0 ready 1",
               {busy, ld_msg, ld_hash_init, start_rnd, upd_hash, done, err, round_idx}, ready);
    end
    step();
    step();
    rst_ni = 1'b1;
    step();
    vecs++;
    if (busy !== 1'b0 || ready !== 1'b1 || round_idx !== 3'd0) begin
      errs++;
      $display("FAIL reset_release: busy %b ready %b idx %0d, required 0 1 0", busy, ready,
               round_idx);
    end
  endtask

  task automatic test_nominal();
    int k0, d0;
    step();
    k0 = kicks;
    d0 = dones;
    push_block(cyc + 1, NR, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(d0, "nominal_done");
    step();
    step();
    check_drained("nominal_queue");
    vecs++;
    if (kicks - k0 !== 8 || dones - d0 !== 1) begin
      errs++;
      $display("FAIL nominal_counts: start_rnd %0d done %0d, required 8 1", kicks - k0,
               dones - d0);
    end
    vecs++;
    if (busy !== 1'b0 || round_idx !== 3'd7) begin
      errs++;
      $display("FAIL nominal_idle: busy %b idx %0d, required 0 7", busy, round_idx);
    end
  endtask

  task automatic test_abort();
    int k0, d0, n;
    bit seen_busy;
    step();
    k0 = kicks;
    d0 = dones;
    push_block(cyc + 1, 3, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (kicks < k0 + 4 && n < 100) begin
      step();
      n++;
    end
    vecs++;
    if (kicks !== k0 + 4) begin
      errs++;
      $display("FAIL abort_reach: start_rnd %0d, required 4", kicks - k0);
    end
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    vecs++;
    if (busy !== 1'b0 || round_idx !== 3'd0 || ready !== 1'b0) begin
      errs++;
      $display("FAIL abort_idle: busy %b idx %0d ready %b, required 0 0 0", busy, round_idx,
               ready);
    end
    start = 1'b1;
    seen_busy = 1'b0;
    n = 0;
    while (!ready && n < 50) begin
      step();
      if (busy) seen_busy = 1'b1;
      n++;
    end
    vecs++;
    if (seen_busy !== 1'b0 || ready !== 1'b1) begin
      errs++;
      $display("FAIL abort_gate: busy_seen %b ready %b, required 0 1", seen_busy, ready);
    end
    push_block(cyc + 1, NR, 1'b1);
    step();
    start = 1'b0;
    wait_done(d0, "abort_rerun");
    step();
    check_drained("abort_queue");
    vecs++;
    if (dones - d0 !== 1 || kicks - k0 !== 12) begin
      errs++;
      $display("FAIL abort_counts: done %0d start_rnd %0d, required 1 12", dones - d0,
               kicks - k0);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    step();
    d0 = dones;
    push_block(cyc + 1, NR, 1'b1);
    start = 1'b1;
    step();
    wait_done(d0, "b2b_first");
    push_block(cyc + 2, NR, 1'b1);
    step();
    vecs++;
    if (busy !== 1'b0 || ready !== 1'b1) begin
      errs++;
      $display("FAIL b2b_gap: busy %b ready %b, required 0 1", busy, ready);
    end
    step();
    start = 1'b0;
    vecs++;
    if (busy !== 1'b1 || ld_msg !== 1'b1) begin
      errs++;
      $display("FAIL b2b_reload: busy %b ld_msg %b, required 1 1", busy, ld_msg);
    end
    wait_done(d0 + 1, "b2b_second");
    step();
    check_drained("b2b_queue");
  endtask

  task automatic test_not_ready();
    int d0;
    step();
    d0 = dones;
    hold_busy = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vecs++;
      if (busy !== 1'b0 || ready !== 1'b0) begin
        errs++;
        $display("FAIL not_ready_hold: busy %b ready %b, required 0 0", busy, ready);
      end
    end
    hold_busy = 1'b0;
    #1;
    vecs++;
    if (ready !== 1'b1) begin
      errs++;
      $display("FAIL not_ready_release: ready %b, required 1", ready);
    end
    push_block(cyc + 1, NR, 1'b1);
    step();
    start = 1'b0;
    wait_done(d0, "not_ready_done");
    step();
    check_drained("not_ready_queue");
  endtask

  task automatic test_reset_mid_run();
    int k0, n;
    step();
    k0 = kicks;
    push_block(cyc + 1, NR, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (kicks < k0 + 2 && n < 100) begin
      step();
      n++;
    end
    step();
    step();
    vecs++;
    if (busy !== 1'b1 || round_idx !== 3'd1) begin
      errs++;
      $display("FAIL mid_run_pre: busy %b idx %0d, required 1 1", busy, round_idx);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    vecs++;
    if ({busy, ld_msg, ld_hash_init, start_rnd, upd_hash, done, err, round_idx} !== 10'd0
        || ready !== 1'b1) begin
      errs++;
      $display("FAIL mid_run_reset: outs %b ready %b, required all 0 ready 1",
               {busy, ld_msg, ld_hash_init, start_rnd, upd_hash, done, err, round_idx}, ready);
    end
    exp_ld_q.delete();
    exp_upd_cyc_q.delete();
    exp_upd_idx_q.delete();
    exp_done_q.delete();
    step();
    rst_ni = 1'b1;
    step();
    vecs++;
    if (busy !== 1'b0 || round_idx !== 3'd0) begin
      errs++;
      $display("FAIL mid_run_after: busy %b idx %0d, required 0 0", busy, round_idx);
    end
  endtask

`ifdef HASH_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int c, d0;
    step();
    d0 = dones;
    push_block(cyc + 1, 0, 1'b0);
    stuck = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    c = cyc;
    while (cyc < c + 11) step();
    vecs++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errs++;
      $display("FAIL timeout_pre: busy %b err %b, required 1 0", busy, err);
    end
    step();
    vecs++;
    if (busy !== 1'b0 || err !== 1'b1 || dones !== d0) begin
      errs++;
      $display("FAIL timeout_hit: busy %b err %b done %0d, required 0 1 0", busy, err,
               dones - d0);
    end
    mdl_clr = 1'b1;
    step();
    mdl_clr = 1'b0;
    stuck = 1'b0;
    push_block(cyc + 1, NR, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    vecs++;
    if (err !== 1'b0) begin
      errs++;
      $display("FAIL timeout_clear: err %b, required 0", err);
    end
    wait_done(d0, "timeout_rerun");
    step();
    check_drained("timeout_queue");
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_abort();
    test_back_to_back();
    test_not_ready();
    test_reset_mid_run();
`ifdef HASH_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
